// File: rtl/cache_ctrl_wb.sv
// rtl/cache_ctrl_wb.sv - direct-mapped cache controller, write-back or write-through, ready-gated memory port
// All outputs are registered; memory-side outputs are derived from the next state.
module cache_ctrl_wb #(
    parameter int ADDR_BITS  = 5,
    parameter int INDEX_BITS = 3,
    parameter int DATA_WIDTH = 8,
    parameter bit WRITE_BACK = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [ADDR_BITS-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_done,
    output logic                  hit,
    output logic                  busy,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic [2:0]            state
);
    localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_FILL      = 3'd3,
        S_RESPOND   = 3'd4,
        S_WTHRU     = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  op_write_q, op_write_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  whit_q, whit_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [LINES-1:0]      dirty_q, dirty_d;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    logic                  data_we;
    logic                  tag_we;
    logic [DATA_WIDTH-1:0] data_wval;

    logic                  cpu_done_q, cpu_done_d;
    logic                  hit_q, hit_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  lookup_hit;
    logic                  victim_dirty;

    assign req_idx      = addr_q[INDEX_BITS-1:0];
    assign req_tag      = addr_q[ADDR_BITS-1:INDEX_BITS];
    assign lookup_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_read || cpu_write) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (op_write_q && !WRITE_BACK) state_d = S_WTHRU;
                else if (lookup_hit)           state_d = S_IDLE;
                else if (victim_dirty)         state_d = S_WRITEBACK;
                else                           state_d = S_FILL;
            end
            S_WRITEBACK: begin
                if (mem_ready) state_d = S_FILL;
            end
            S_FILL: begin
                if (mem_ready) state_d = S_RESPOND;
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            S_WTHRU: begin
                if (mem_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch, array updates and CPU-side responses, keyed on the current state.
    always_comb begin
        op_write_d  = op_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        whit_d      = whit_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        data_we     = 1'b0;
        tag_we      = 1'b0;
        data_wval   = wdata_q;
        cpu_done_d  = 1'b0;
        hit_d       = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_read || cpu_write) begin
                    op_write_d = cpu_write;
                    addr_d     = cpu_addr;
                    wdata_d    = cpu_wdata;
                end
            end
            S_LOOKUP: begin
                if (op_write_q && !WRITE_BACK) begin
                    whit_d  = lookup_hit;
                    data_we = lookup_hit;
                end else if (lookup_hit) begin
                    cpu_done_d = 1'b1;
                    hit_d      = 1'b1;
                    if (op_write_q) begin
                        data_we          = 1'b1;
                        dirty_d[req_idx] = 1'b1;
                    end else begin
                        cpu_rdata_d = data_q[req_idx];
                    end
                end
            end
            S_WRITEBACK: begin
                if (mem_ready) dirty_d[req_idx] = 1'b0;
            end
            S_FILL: begin
                if (mem_ready) begin
                    data_we          = 1'b1;
                    data_wval        = mem_rdata;
                    tag_we           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                end
            end
            S_RESPOND: begin
                cpu_done_d = 1'b1;
                if (op_write_q) begin
                    data_we          = 1'b1;
                    dirty_d[req_idx] = 1'b1;
                end else begin
                    cpu_rdata_d = data_q[req_idx];
                end
            end
            S_WTHRU: begin
                if (mem_ready) begin
                    cpu_done_d = 1'b1;
                    hit_d      = whit_q;
                end
            end
            default: ;
        endcase
    end

    // Memory outputs follow the state being entered so they are valid the cycle after the transition.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        mem_read_d  = (state_d == S_FILL);
        mem_write_d = (state_d == S_WRITEBACK) || (state_d == S_WTHRU);
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_d)
            S_WRITEBACK: begin
                mem_addr_d  = {tag_q[req_idx], req_idx};
                mem_wdata_d = data_q[req_idx];
            end
            S_FILL: begin
                mem_addr_d = addr_q;
            end
            S_WTHRU: begin
                mem_addr_d  = addr_q;
                mem_wdata_d = wdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_write_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            whit_q      <= 1'b0;
            valid_q     <= '0;
            dirty_q     <= '0;
            cpu_done_q  <= 1'b0;
            hit_q       <= 1'b0;
            busy_q      <= 1'b0;
            cpu_rdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            op_write_q  <= op_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            whit_q      <= whit_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            cpu_done_q  <= cpu_done_d;
            hit_q       <= hit_d;
            busy_q      <= busy_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Tag and data storage carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (!reset && tag_we)  tag_q[req_idx]  <= req_tag;
        if (!reset && data_we) data_q[req_idx] <= data_wval;
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign hit       = hit_q;
    assign busy      = busy_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign state     = state_q;

endmodule
